// File: rtl/conv_kernel_scheduler_pkg.sv
// Shared definitions for the Conv2d kernel scheduler.
// Holds the sequencer state encoding and the layer count width.
package conv_kernel_scheduler_pkg;

    localparam int CNT_W_DEF        = 9;
    localparam int KER_WORDS_PER_CH = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PRIME,
        ST_ISSUE,
        ST_WAIT,
        ST_FEND
    } sched_state_e;

endpackage

// File: rtl/conv_kernel_scheduler_counter.sv
// Generic up-counter with synchronous clear and enable.
// Used for the channel and filter indices of the kernel scheduler.
module counter #(
    parameter int BITWIDTH = 9
) (
    input  logic                clk,
    input  logic                Reset,
    input  logic                clr,
    input  logic                en,
    output logic [BITWIDTH-1:0] count
);

    logic [BITWIDTH-1:0] count_q;
    logic [BITWIDTH-1:0] count_d;

    // Clear wins over enable so a restart never sees a stale increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + BITWIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/conv_kernel_scheduler.sv
// Layer-level sequencer: loads one kernel set per filter into the kernel BRAM,
// then steps the BRAM read port channel by channel in lockstep with the datapath.
module conv_kernel_scheduler
    import conv_kernel_scheduler_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             start,
    input  logic [CNT_W-1:0] CHANNEL_SIZE,
    input  logic [CNT_W-1:0] FILTER_COUNT,
    output logic             load_BRAM_dina,
    input  logic             last_loading_1ker,
    output logic             update_BRAM_doutb,
    input  logic             last_channel,
    output logic             chan_start,
    input  logic             chan_done,
    output logic             filter_done,
    output logic             done,
    output logic             busy,
    output logic [CNT_W-1:0] filter_idx,
    output logic [CNT_W-1:0] channel_idx,
    output logic             err
);

    sched_state_e     state_q, state_d;
    logic             load_q, load_d;
    logic             chan_start_q, chan_start_d;
    logic             filter_done_q, filter_done_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] chan_size_q, chan_size_d;
    logic [CNT_W-1:0] filt_count_q, filt_count_d;

    logic             ch_clr, ch_en;
    logic             f_clr, f_en;
    logic             last_ch, last_f;
    logic [CNT_W-1:0] channel_cnt, filter_cnt;

    counter #(.BITWIDTH(CNT_W)) u_channel_cnt (
        .clk   (clk),
        .Reset (Reset),
        .clr   (ch_clr),
        .en    (ch_en),
        .count (channel_cnt)
    );

    counter #(.BITWIDTH(CNT_W)) u_filter_cnt (
        .clk   (clk),
        .Reset (Reset),
        .clr   (f_clr),
        .en    (f_en),
        .count (filter_cnt)
    );

    // Last-channel/filter decisions rely only on the latched counts, never on last_channel.
    assign last_ch = (channel_cnt == chan_size_q - CNT_W'(1));
    assign last_f  = (filter_cnt == filt_count_q - CNT_W'(1));

    always_comb begin
        state_d       = state_q;
        load_d        = 1'b0;
        chan_start_d  = 1'b0;
        filter_done_d = 1'b0;
        done_d        = 1'b0;
        err_d         = err_q;
        chan_size_d   = chan_size_q;
        filt_count_d  = filt_count_q;
        ch_clr        = 1'b0;
        ch_en         = 1'b0;
        f_clr         = 1'b0;
        f_en          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((CHANNEL_SIZE != '0) && (FILTER_COUNT != '0)) begin
                        chan_size_d  = CHANNEL_SIZE;
                        filt_count_d = FILTER_COUNT;
                        err_d        = 1'b0;
                        ch_clr       = 1'b1;
                        f_clr        = 1'b1;
                        load_d       = 1'b1;
                        state_d      = ST_LOAD;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (last_loading_1ker) begin
                    state_d = ST_PRIME;
                end else begin
                    load_d = 1'b1;
                end
            end
            ST_PRIME: begin
                chan_start_d = 1'b1;
                state_d      = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (chan_done) begin
                    if (last_ch != last_channel) begin
                        err_d = 1'b1;
                    end
                    if (last_ch) begin
                        filter_done_d = 1'b1;
                        done_d        = last_f;
                        state_d       = ST_FEND;
                    end else begin
                        ch_en   = 1'b1;
                        state_d = ST_PRIME;
                    end
                end
            end
            ST_FEND: begin
                if (last_f) begin
                    state_d = ST_IDLE;
                end else begin
                    f_en    = 1'b1;
                    ch_clr  = 1'b1;
                    load_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q       <= ST_IDLE;
            load_q        <= 1'b0;
            chan_start_q  <= 1'b0;
            filter_done_q <= 1'b0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            chan_size_q   <= '0;
            filt_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            load_q        <= load_d;
            chan_start_q  <= chan_start_d;
            filter_done_q <= filter_done_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            chan_size_q   <= chan_size_d;
            filt_count_q  <= filt_count_d;
        end
    end

    // The read-address advance must land in the same cycle as chan_done, so it stays combinational.
    assign update_BRAM_doutb = (state_q == ST_WAIT) && chan_done;

    assign load_BRAM_dina = load_q;
    assign chan_start     = chan_start_q;
    assign filter_done    = filter_done_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign err            = err_q;
    assign filter_idx     = filter_cnt;
    assign channel_idx    = channel_cnt;

endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Scoreboard bench for conv_kernel_scheduler with kernel BRAM and datapath responders.
// Expected pulse sequences come from a per-layer model and are checked by a separate monitor.
module tb_conv_kernel_scheduler;

    localparam int EV_LOAD  = 1;
    localparam int EV_START = 2;
    localparam int EV_UPD   = 3;
    localparam int EV_FDONE = 4;
    localparam int EV_DONE  = 5;
    localparam int EV_NONE  = 99;

    typedef struct {
        int kind;
        int f;
        int c;
        bit chk;
    } ev_t;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] CHANNEL_SIZE = '0;
    logic [8:0] FILTER_COUNT = '0;
    logic       load_BRAM_dina;
    logic       last_loading_1ker = 1'b0;
    logic       update_BRAM_doutb;
    logic       last_channel = 1'b0;
    logic       chan_start;
    logic       chan_done = 1'b0;
    logic       filter_done;
    logic       done;
    logic       busy;
    logic [8:0] filter_idx;
    logic [8:0] channel_idx;
    logic       err;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  ref_cycle = 0;
    bit  exp_err = 1'b0;

    int  cur_cs = 1;
    int  cur_last_pos = 0;
    int  load_delay = 1;
    int  d_min = 1;
    int  d_max = 1;
    bit  spurious = 1'b0;
    bit  upd_prev = 1'b0;

    conv_kernel_scheduler dut (
        .clk               (clk),
        .Reset             (Reset),
        .start             (start),
        .CHANNEL_SIZE      (CHANNEL_SIZE),
        .FILTER_COUNT      (FILTER_COUNT),
        .load_BRAM_dina    (load_BRAM_dina),
        .last_loading_1ker (last_loading_1ker),
        .update_BRAM_doutb (update_BRAM_doutb),
        .last_channel      (last_channel),
        .chan_start        (chan_start),
        .chan_done         (chan_done),
        .filter_done       (filter_done),
        .done              (done),
        .busy              (busy),
        .filter_idx        (filter_idx),
        .channel_idx       (channel_idx),
        .err               (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic observe(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checkOutput("unexpected_event", kind, EV_NONE);
        end else begin
            e = exp_q.pop_front();
            checkOutput("event_kind", kind, e.kind);
            if (e.chk) begin
                checkOutput("event_filter_idx", filter_idx, e.f);
                checkOutput("event_channel_idx", channel_idx, e.c);
            end
        end
    endtask

    // Reference model: the full ordered pulse sequence of one layer.
    task automatic pushLayer(input int cs, input int fc);
        for (int f = 0; f < fc; f++) begin
            exp_q.push_back('{EV_LOAD, f, 0, 1'b1});
            for (int c = 0; c < cs; c++) begin
                exp_q.push_back('{EV_START, f, c, 1'b1});
                exp_q.push_back('{EV_UPD, f, c, 1'b1});
            end
            exp_q.push_back('{EV_FDONE, f, cs - 1, 1'b1});
        end
        exp_q.push_back('{EV_DONE, fc - 1, cs - 1, 1'b1});
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a pulse.
    initial begin
        bit load_prev;
        load_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (Reset) begin
                load_prev = 1'b0;
                continue;
            end
            if (load_BRAM_dina && !load_prev) observe(EV_LOAD);
            load_prev = load_BRAM_dina;
            if (chan_start) begin
                observe(EV_START);
                checkOutput("chan_start_latency", cyc - ref_cycle, 2);
            end
            if (update_BRAM_doutb) begin
                observe(EV_UPD);
                ref_cycle = cyc;
                upd_prev = 1'b1;
            end
            if (load_BRAM_dina && last_loading_1ker) ref_cycle = cyc;
            if (filter_done) begin
                observe(EV_FDONE);
                checkOutput("filter_done_latency", cyc - ref_cycle, 1);
            end
            if (done) observe(EV_DONE);
        end
    end

    // Kernel BRAM and datapath responders.
    initial begin
        int  dp_cnt;
        int  load_cnt;
        int  rdaddr;
        bit  spur_start_set;
        dp_cnt = 0;
        load_cnt = 0;
        rdaddr = 0;
        spur_start_set = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (Reset) begin
                dp_cnt = 0;
                load_cnt = 0;
                rdaddr = 0;
                upd_prev = 1'b0;
                chan_done = 1'b0;
                last_loading_1ker = 1'b0;
                last_channel = 1'b0;
                continue;
            end
            if (spur_start_set) begin
                start = 1'b0;
                spur_start_set = 1'b0;
            end
            if (upd_prev) begin
                rdaddr = (rdaddr == cur_cs - 1) ? 0 : rdaddr + 1;
                upd_prev = 1'b0;
            end
            last_channel = (rdaddr == cur_last_pos);
            chan_done = 1'b0;
            if (dp_cnt > 0) begin
                dp_cnt--;
                if (dp_cnt == 0) chan_done = 1'b1;
            end
            if (chan_start) dp_cnt = int'($urandom_range(d_max, d_min));
            last_loading_1ker = 1'b0;
            if (load_BRAM_dina) begin
                load_cnt++;
                if (spurious && load_cnt == 2) begin
                    chan_done = 1'b1;
                    start = 1'b1;
                    spur_start_set = 1'b1;
                    CHANNEL_SIZE = 9'($urandom_range(9, 1));
                end
                if (load_cnt == load_delay) begin
                    last_loading_1ker = 1'b1;
                    load_cnt = 0;
                end
            end else begin
                load_cnt = 0;
            end
        end
    end

    task automatic doReset();
        @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic applyStimulus(input int cs, input int fc, input int ld, input int dmin,
                                 input int dmax, input int lastpos, input bit spur);
        int budget;
        bit accepted;
        bit got;
        cur_cs = cs;
        cur_last_pos = lastpos;
        load_delay = ld;
        d_min = dmin;
        d_max = dmax;
        spurious = spur;
        accepted = (cs != 0) && (fc != 0);
        if (accepted) begin
            pushLayer(cs, fc);
            exp_err = (lastpos != cs - 1);
        end else begin
            exp_q.push_back('{EV_DONE, 0, 0, 1'b0});
        end
        budget = fc * (ld + 8 + cs * (dmax + 4)) + 100;
        @(posedge clk);
        #1;
        CHANNEL_SIZE = 9'(cs);
        FILTER_COUNT = 9'(fc);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        CHANNEL_SIZE = 9'($urandom_range(511, 0));
        FILTER_COUNT = 9'($urandom_range(511, 0));
        @(negedge clk);
        if (accepted) begin
            checkOutput("load_after_start", load_BRAM_dina, 1);
            checkOutput("busy_after_start", busy, 1);
            checkOutput("err_cleared_on_start", err, 0);
            got = 1'b0;
            for (int i = 0; i < budget; i++) begin
                @(negedge clk);
                if (done) begin
                    got = 1'b1;
                    break;
                end
            end
            checkOutput("done_within_budget", got, 1);
            if (!got) doReset();
        end else begin
            checkOutput("zero_count_done", done, 1);
            checkOutput("zero_count_busy", busy, 0);
            checkOutput("zero_count_no_load", load_BRAM_dina, 0);
        end
        repeat (3) @(negedge clk);
        checkOutput("busy_after_layer", busy, 0);
        checkOutput("err_after_layer", err, exp_err);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
    endtask

    task automatic resetMidLayer();
        bit found;
        cur_cs = 3;
        cur_last_pos = 2;
        load_delay = 2;
        d_min = 20;
        d_max = 20;
        spurious = 1'b0;
        pushLayer(3, 2);
        @(posedge clk);
        #1;
        CHANNEL_SIZE = 9'd3;
        FILTER_COUNT = 9'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (chan_start && filter_idx == 9'd1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("reached_filter1", found, 1);
        @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk);
        #1;
        Reset = 1'b0;
        exp_q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_load", load_BRAM_dina, 0);
        checkOutput("rst_chan_start", chan_start, 0);
        checkOutput("rst_update", update_BRAM_doutb, 0);
        checkOutput("rst_filter_done", filter_done, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_filter_idx", filter_idx, 0);
        checkOutput("rst_channel_idx", channel_idx, 0);
        repeat (30) @(negedge clk);
    endtask

    initial begin
        int cs;
        int fc;
        $display("[TB] conv_kernel_scheduler bench starting");
        Reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_load", load_BRAM_dina, 0);
        checkOutput("reset_chan_start", chan_start, 0);
        checkOutput("reset_filter_done", filter_done, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_err", err, 0);
        checkOutput("reset_filter_idx", filter_idx, 0);
        checkOutput("reset_channel_idx", channel_idx, 0);
        @(posedge clk);
        #1;
        Reset = 1'b0;

        $display("[TB] ideal responders, 3 channels x 2 filters");
        applyStimulus(3, 2, 1, 1, 1, 2, 1'b0);
        $display("[TB] delayed load and random chan_done");
        applyStimulus(3, 2, 50, 1, 20, 2, 1'b0);
        $display("[TB] early last_channel");
        applyStimulus(3, 1, 1, 1, 3, 1, 1'b0);
        applyStimulus(2, 2, 3, 1, 4, 1, 1'b0);
        $display("[TB] spurious start and chan_done during LOAD");
        applyStimulus(4, 3, 5, 1, 10, 3, 1'b1);
        $display("[TB] reset in WAIT of filter 1");
        resetMidLayer();
        applyStimulus(3, 2, 2, 1, 5, 2, 1'b0);
        $display("[TB] zero counts");
        applyStimulus(0, 3, 1, 1, 1, 0, 1'b0);
        applyStimulus(2, 0, 1, 1, 1, 0, 1'b0);
        $display("[TB] 256 channels, 1 filter");
        applyStimulus(256, 1, 2, 1, 2, 255, 1'b0);
        $display("[TB] random layers");
        for (int k = 0; k < 4; k++) begin
            cs = int'($urandom_range(6, 1));
            fc = int'($urandom_range(3, 1));
            applyStimulus(cs, fc, int'($urandom_range(8, 1)), 1, int'($urandom_range(6, 1)), cs - 1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_kernel_scheduler.md
# conv_kernel_scheduler

Layer-level sequencer for the kernel BRAM of the Conv2d engine. For each output filter it loads one kernel set (CHANNEL_SIZE 3×3 kernels) over AXI-Stream into the kernel BRAM. It then steps the BRAM read port one input channel at a time, handshaking with the convolution datapath, and repeats for FILTER_COUNT filters. It sits between the layer top controller (start/done) and the kernel BRAM / conv datapath.

## Interface
- CNT_W, 9, width of channel/filter count and index ports (supports 1..256 of each)
- clk  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a layer; ignored while busy=1
- CHANNEL_SIZE  in  CNT_W  input channels per filter; latched on accepted start
- FILTER_COUNT  in  CNT_W  output filters per layer; latched on accepted start
- load_BRAM_dina  out  1  level; kernel BRAM accepts stream words while high
- last_loading_1ker  in  1  from kernel BRAM; final word of current kernel set written
- update_BRAM_doutb  out  1  one-cycle pulse; advance kernel BRAM read address
- last_channel  in  1  from kernel BRAM; read address is on final channel
- chan_start  out  1  one-cycle pulse; datapath may consume kernel_BRAM_doutb
- chan_done  in  1  one-cycle pulse from datapath; current channel finished
- filter_done  out  1  one-cycle pulse after the last channel of a filter
- done  out  1  one-cycle pulse after the last filter
- busy  out  1  high in every state except IDLE
- filter_idx  out  CNT_W  current filter, 0-based
- channel_idx  out  CNT_W  current channel, 0-based
- err  out  1  sticky; channel count mismatch with last_channel; cleared on accepted start

## Operation
- States: IDLE, LOAD, PRIME, ISSUE, WAIT, FEND.
- IDLE: start=1 and both counts nonzero → latch config, clear indices and err → LOAD. Zero count: start is ignored and done pulses the next cycle.
- LOAD: load_BRAM_dina=1. On last_loading_1ker=1 → PRIME.
- PRIME: one wait cycle for BRAM read latency (doutb for current address becomes valid) → ISSUE.
- ISSUE: chan_start=1 for one cycle → WAIT.
- WAIT, on chan_done=1:
  - update_BRAM_doutb=1 in the same cycle (issued on the last channel as well, so kernel BRAM wraps its read counter).
  - err set if (channel_idx==CHANNEL_SIZE-1) differs from last_channel.
  - Not the last channel: channel_idx+1 → PRIME.
  - Last channel: → FEND.
- Last-channel decision uses the internal count only.
- FEND: filter_done=1.
  - filter_idx==FILTER_COUNT-1: done=1 → IDLE.
  - Otherwise: filter_idx+1, channel_idx=0 → LOAD.
- Inputs outside their state are ignored: chan_done outside WAIT, last_loading_1ker outside LOAD, start while busy.
- Index compares use CNT_W-bit unsigned arithmetic. Counters never wrap inside a layer.

## Timing
- Reset: all outputs 0, state IDLE, indices 0, err 0. Reset mid-layer aborts immediately with no done or filter_done. kernel BRAM shares Reset.
- Start at cycle 0 → load_BRAM_dina high from cycle 1.
- load_BRAM_dina stays high through the cycle last_loading_1ker is sampled and is low the next cycle.
- last_loading_1ker → PRIME (+1) → chan_start (+2).
- chan_done → update_BRAM_doutb (same cycle) → next chan_start 2 cycles later.
- Last chan_done → filter_done +1 → load_BRAM_dina +2 (next filter) or busy low +2.
- All outputs registered except update_BRAM_doutb, which is a decode of WAIT & chan_done.

## Structure
- Shared conv package: state enum, CNT_W default, KER_WORDS_PER_CH=1 constant.
- One sub-module is natural: reuse existing `counter` (BITWIDTH=CNT_W) for channel_idx and filter_idx, driven by FSM enable/reset.
- The FSM lives in this module.

## Test plan
- CHANNEL_SIZE=3, FILTER_COUNT=2, ideal responders:
  - 2 LOAD phases.
  - 6 chan_start, 6 update_BRAM_doutb.
  - filter_done at channel_idx=2 twice.
  - One done; err=0.
- Delayed last_loading_1ker (50 cycles) and chan_done (1..20 random cycles) → identical pulse counts and order; chan_start exactly 2 cycles after each prior chan_done.
- last_channel asserted early (at channel 1 of 3) → err=1 sticky, sequencing still completes 3 channels; next start clears err.
- start while busy, spurious chan_done in LOAD → ignored; counts unchanged.
- Reset asserted in WAIT of filter 1 → next cycle busy=0, all outputs 0; a fresh start runs a full layer correctly.
- CHANNEL_SIZE=0 → no LOAD, done pulse one cycle after start; CHANNEL_SIZE=256, FILTER_COUNT=1 → channel_idx reaches 255, done once.
